// File: rtl/mtype_uop_sequencer_pkg.sv
// Shared encodings for the M-type micro-op sequencer: func3 codes, ALU codes, FSM states.
package mtype_uop_sequencer_pkg;

  localparam logic [2:0] M_LD   = 3'b000;
  localparam logic [2:0] M_ST   = 3'b001;
  localparam logic [2:0] M_MVTR = 3'b010;
  localparam logic [2:0] M_MVTM = 3'b011;
  localparam logic [2:0] M_MOPA = 3'b100;

  localparam logic [3:0] ALU_ADD     = 4'b0000;
  localparam logic [3:0] ALU_MOPA    = 4'b1010;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Beat-index width: enough for max(rows, cols) beats, never narrower than 1 bit.
  function automatic int idx_width(input int rows, input int cols);
    int m;
    m = (rows > cols) ? rows : cols;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/mtype_uop_sequencer_decode.sv
// Combinational func3 decoder: ALU control code, MOPA flag and legality for an M-type op.
module mtype_decode
  import mtype_uop_sequencer_pkg::*;
(
  input  logic [2:0] func3_i,
  output logic [3:0] alu_ctrl_o,
  output logic       is_mopa_o,
  output logic       legal_o
);

  always_comb begin
    alu_ctrl_o = ALU_ILLEGAL;
    is_mopa_o  = 1'b0;
    legal_o    = 1'b0;
    case (func3_i)
      M_LD, M_ST, M_MVTR, M_MVTM: begin
        alu_ctrl_o = ALU_ADD;
        legal_o    = 1'b1;
      end
      M_MOPA: begin
        alu_ctrl_o = ALU_MOPA;
        is_mopa_o  = 1'b1;
        legal_o    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mtype_uop_sequencer.sv
// Multi-cycle M-type controller: accepts one decoded op and issues one micro-op per row/beat.
// Handshakes: a transfer happens on a cycle where valid && ready; payload is held while valid && !ready.
module mtype_uop_sequencer
  import mtype_uop_sequencer_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int ADDR_W     = 32,
  parameter int ROW_STRIDE = 16,
  parameter int TILE_W     = 2,
  localparam int IDX_W     = idx_width(ROWS, COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_func3,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [TILE_W-1:0] in_tile,
  output logic              uop_valid,
  input  logic              uop_ready,
  output logic [3:0]        uop_alu_ctrl,
  output logic [ADDR_W-1:0] uop_addr,
  output logic [IDX_W-1:0]  uop_row,
  output logic [TILE_W-1:0] uop_tile,
  output logic              uop_first,
  output logic              uop_last,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output state_e            dbg_state
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  beat_q, beat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TILE_W-1:0] tile_q, tile_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic              mopa_q, mopa_d;
  logic              illegal_q, illegal_d;

  logic [3:0] dec_ctrl;
  logic       dec_mopa, dec_legal;
  logic       accept, beat_fire, last_beat;

  mtype_decode u_decode (
    .func3_i    (in_func3),
    .alu_ctrl_o (dec_ctrl),
    .is_mopa_o  (dec_mopa),
    .legal_o    (dec_legal)
  );

  assign accept    = in_valid && in_ready;
  assign beat_fire = (state_q == ST_ISSUE) && uop_ready;
  assign last_beat = mopa_q ? (beat_q == IDX_W'(COLS - 1)) : (beat_q == IDX_W'(ROWS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (accept && dec_legal) state_d = ST_ISSUE;
        ST_ISSUE: if (beat_fire && last_beat) state_d = ST_DONE;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // The running address is accumulated rather than multiplied; MOPA keeps the base for every beat.
  always_comb begin
    beat_d    = beat_q;
    addr_d    = addr_q;
    tile_d    = tile_q;
    ctrl_d    = ctrl_q;
    mopa_d    = mopa_q;
    illegal_d = 1'b0;
    if (accept) begin
      beat_d    = '0;
      addr_d    = in_base;
      tile_d    = in_tile;
      ctrl_d    = dec_ctrl;
      mopa_d    = dec_mopa;
      illegal_d = !dec_legal;
    end else if (beat_fire && !last_beat && !flush) begin
      beat_d = beat_q + IDX_W'(1);
      if (!mopa_q) addr_d = addr_q + ADDR_W'(ROW_STRIDE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q    <= '0;
      addr_q    <= '0;
      tile_q    <= '0;
      ctrl_q    <= ALU_ILLEGAL;
      mopa_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      tile_q    <= tile_d;
      ctrl_q    <= ctrl_d;
      mopa_q    <= mopa_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    in_ready     = (state_q == ST_IDLE) && !flush;
    busy         = (state_q != ST_IDLE);
    done         = (state_q == ST_DONE);
    illegal      = illegal_q;
    uop_valid    = (state_q == ST_ISSUE);
    uop_alu_ctrl = ALU_ILLEGAL;
    uop_addr     = '0;
    uop_row      = '0;
    uop_tile     = '0;
    uop_first    = 1'b0;
    uop_last     = 1'b0;
    dbg_state    = state_q;
    if (state_q == ST_ISSUE) begin
      uop_alu_ctrl = ctrl_q;
      uop_addr     = addr_q;
      uop_row      = beat_q;
      uop_tile     = tile_q;
      uop_first    = (beat_q == '0);
      uop_last     = last_beat;
    end
  end

endmodule

// File: tb/tb_mtype_uop_sequencer.sv
// Bench for mtype_uop_sequencer: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-level model (a queue of the micro-ops each op must produce).
module tb_mtype_uop_sequencer;
  import mtype_uop_sequencer_pkg::*;

  localparam int ROWS       = 4;
  localparam int COLS       = 4;
  localparam int ADDR_W     = 32;
  localparam int ROW_STRIDE = 16;
  localparam int TILE_W     = 2;
  localparam int IDX_W      = 2;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, uop_valid, uop_ready;
  logic              uop_first, uop_last, busy, done, illegal;
  logic [2:0]        in_func3;
  logic [ADDR_W-1:0] in_base, uop_addr;
  logic [TILE_W-1:0] in_tile, uop_tile;
  logic [3:0]        uop_alu_ctrl;
  logic [IDX_W-1:0]  uop_row;
  state_e            dbg_state;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        ctrl;
    logic [IDX_W-1:0]  row;
    logic [TILE_W-1:0] tile;
    logic              first;
    logic              last;
  } uop_t;

  uop_t exp_q[$];
  logic done_due, illegal_due;
  int   n_cmp, n_fail;

  logic [31:0] t1_addr [4];
  logic [31:0] t2_addr [6];
  int          t2_row  [6];
  logic [31:0] t5_addr [4];

  mtype_uop_sequencer #(
    .ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W), .ROW_STRIDE(ROW_STRIDE), .TILE_W(TILE_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_func3(in_func3), .in_base(in_base), .in_tile(in_tile),
    .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_alu_ctrl(uop_alu_ctrl), .uop_addr(uop_addr),
    .uop_row(uop_row), .uop_tile(uop_tile), .uop_first(uop_first), .uop_last(uop_last),
    .busy(busy), .done(done), .illegal(illegal), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] base, input logic [1:0] tile);
    in_valid = 1'b1;
    in_func3 = f3;
    in_base  = base;
    in_tile  = tile;
    step();
    in_valid = 1'b0;
  endtask

  function automatic bit is_legal(input logic [2:0] f3);
    return f3 inside {M_LD, M_ST, M_MVTR, M_MVTM, M_MOPA};
  endfunction

  // ---------------- reference model + per-cycle compare ----------------
  initial begin
    uop_t cur;
    bit   e_valid, e_done, e_idle, ill_n;
    done_due    = 1'b0;
    illegal_due = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_uop_valid", uop_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_illegal", illegal, 0);
        check("rst_in_ready", in_ready, !flush);
        check("rst_ctrl", uop_alu_ctrl, 4'b1111);
      end else begin
        e_valid = exp_q.size() > 0;
        e_done  = !e_valid && done_due;
        e_idle  = !e_valid && !done_due;
        check("m_uop_valid", uop_valid, e_valid);
        check("m_busy", busy, !e_idle);
        check("m_done", done, e_done);
        check("m_in_ready", in_ready, e_idle && !flush);
        check("m_illegal", illegal, illegal_due);
        if (e_valid) begin
          cur = exp_q[0];
          check("m_addr", uop_addr, cur.addr);
          check("m_ctrl", uop_alu_ctrl, cur.ctrl);
          check("m_row", uop_row, cur.row);
          check("m_tile", uop_tile, cur.tile);
          check("m_first", uop_first, cur.first);
          check("m_last", uop_last, cur.last);
        end else begin
          check("m_ctrl_idle", uop_alu_ctrl, 4'b1111);
        end
      end
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        done_due    = 1'b0;
        illegal_due = 1'b0;
      end else begin
        ill_n = 1'b0;
        if (flush) begin
          exp_q.delete();
          done_due = 1'b0;
        end else if (exp_q.size() > 0) begin
          if (uop_ready) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) done_due = 1'b1;
          end
        end else if (done_due) begin
          done_due = 1'b0;
        end else if (in_valid) begin
          if (is_legal(in_func3)) begin
            int n;
            n = (in_func3 == M_MOPA) ? COLS : ROWS;
            for (int i = 0; i < n; i++) begin
              cur.addr  = (in_func3 == M_MOPA) ? in_base : 32'(in_base + i * ROW_STRIDE);
              cur.ctrl  = (in_func3 == M_MOPA) ? ALU_MOPA : ALU_ADD;
              cur.row   = IDX_W'(i);
              cur.tile  = in_tile;
              cur.first = (i == 0);
              cur.last  = (i == n - 1);
              exp_q.push_back(cur);
            end
          end else begin
            ill_n = 1'b1;
          end
        end
        illegal_due = ill_n;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0;
    n_fail = 0;
    t1_addr = '{32'h1000, 32'h1010, 32'h1020, 32'h1030};
    t2_addr = '{32'h1000, 32'h1010, 32'h1010, 32'h1010, 32'h1020, 32'h1030};
    t2_row  = '{0, 1, 1, 1, 2, 3};
    t5_addr = '{32'hFFFF_FFF0, 32'h0000_0000, 32'h0000_0010, 32'h0000_0020};
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_func3 = '0; in_base = '0; in_tile = '0;
    uop_ready = 1'b1;
    step();
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_ctrl", uop_alu_ctrl, 4'b1111);
    check("reset_addr", uop_addr, 0);
    step();
    rst = 1'b0;
    step();

    // 1: M_LD, always ready
    issue(M_LD, 32'h1000, 2'd2);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      check("t1_valid", uop_valid, 1);
      check("t1_addr", uop_addr, t1_addr[b]);
      check("t1_row", uop_row, b);
      check("t1_tile", uop_tile, 2);
      check("t1_ctrl", uop_alu_ctrl, ALU_ADD);
      check("t1_first", uop_first, b == 0);
      check("t1_last", uop_last, b == 3);
      step();
    end
    @(negedge clk);
    check("t1_done", done, 1);
    check("t1_valid_done", uop_valid, 0);
    check("t1_in_ready_done", in_ready, 0);
    step();
    @(negedge clk);
    check("t1_in_ready_after", in_ready, 1);
    check("t1_done_after", done, 0);

    // 2: same op, datapath stalls at T+2 and T+3
    issue(M_LD, 32'h1000, 2'd2);
    for (int k = 0; k < 6; k++) begin
      uop_ready = !(k == 1 || k == 2);
      @(negedge clk);
      check("t2_valid", uop_valid, 1);
      check("t2_row", uop_row, t2_row[k]);
      check("t2_addr", uop_addr, t2_addr[k]);
      step();
    end
    uop_ready = 1'b1;
    @(negedge clk);
    check("t2_done", done, 1);
    step();

    // 3: M_MOPA holds the base address
    issue(M_MOPA, 32'h40, 2'd1);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      check("t3_ctrl", uop_alu_ctrl, ALU_MOPA);
      check("t3_addr", uop_addr, 32'h40);
      check("t3_row", uop_row, b);
      step();
    end
    @(negedge clk);
    check("t3_done", done, 1);
    step();

    // 4: illegal func3
    issue(3'b111, 32'h80, 2'd0);
    @(negedge clk);
    check("t4_illegal", illegal, 1);
    check("t4_in_ready", in_ready, 1);
    check("t4_valid", uop_valid, 0);
    check("t4_ctrl", uop_alu_ctrl, 4'b1111);
    step();
    @(negedge clk);
    check("t4_illegal_clear", illegal, 0);
    check("t4_done", done, 0);
    check("t4_valid2", uop_valid, 0);
    step();

    // 5: M_ST wraps the address
    issue(M_ST, 32'hFFFF_FFF0, 2'd3);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      check("t5_addr", uop_addr, t5_addr[b]);
      step();
    end
    step();

    // 6a: flush on beat 2
    issue(M_LD, 32'h2000, 2'd0);
    step();
    step();
    flush = 1'b1;
    @(negedge clk);
    check("t6_row_at_flush", uop_row, 2);
    step();
    flush = 1'b0;
    @(negedge clk);
    check("t6_valid", uop_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    step();
    @(negedge clk);
    check("t6_done_later", done, 0);

    // 6b: flush beats in_valid in IDLE
    flush = 1'b1;
    in_valid = 1'b1;
    in_func3 = M_LD;
    #1;
    check("t6_flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("t6_flush_noaccept", busy, 0);
    step();

    // 6c: async reset mid-op
    issue(M_MOPA, 32'h500, 2'd1);
    step();
    rst = 1'b1;
    #1;
    check("t6_rst_valid", uop_valid, 0);
    check("t6_rst_in_ready", in_ready, 1);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ctrl", uop_alu_ctrl, 4'b1111);
    step();
    rst = 1'b0;
    step();

    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_func3  = 3'($urandom_range(0, 7));
      in_base   = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFE0 + 32'($urandom_range(0, 31)) : $urandom;
      in_tile   = 2'($urandom_range(0, 3));
      uop_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 599) == 0);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; rst = 1'b0; uop_ready = 1'b1;
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
